// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit 7-segment driver: captures a packed hex/BCD word and scans one digit per slot.
// Optional decimal-point path is built only when SEG_MUX_DP_EN is defined.
module seven_segment_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    hex_en,
    input  logic                    blank_lz,
`ifdef SEG_MUX_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp_out,
`endif
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic                  POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_POL = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] EN_POL  = {NUM_DIGITS{POL}};

    logic [PW-1:0]             prescaler_q, prescaler_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     en_q, en_d;
    logic                      tick;
    logic [3:0]                digit;
    logic                      upper_zero;
    logic                      zero_run;
    logic                      blank;
    logic [NUM_DIGITS-1:0]     onehot;

    function automatic logic [6:0] decode(input logic [3:0] code, input logic hx);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = hx ? 7'b1110111 : 7'b0000000;
            4'hB: s = hx ? 7'b0011111 : 7'b0000000;
            4'hC: s = hx ? 7'b1001110 : 7'b0000000;
            4'hD: s = hx ? 7'b0111101 : 7'b0000000;
            4'hE: s = hx ? 7'b1001111 : 7'b0000000;
            default: s = hx ? 7'b1000111 : 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick        = (prescaler_q == PW'(REFRESH_DIV - 1));
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        shadow_d = load ? val_in : shadow_q;

        // Walk from the most significant digit down so upper_zero covers digits i..N-1.
        digit      = '0;
        zero_run   = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_q[4*i +: 4] == 4'h0);
            if (IW'(i) == idx_d) begin
                digit     = shadow_q[4*i +: 4];
                zero_run  = upper_zero;
                onehot[i] = 1'b1;
            end
        end
        blank = blank_lz && (idx_d != '0) && zero_run;

        seg_d = seg_q;
        en_d  = en_q;
        if (tick) begin
            seg_d = (blank ? 7'b0000000 : decode(digit, hex_en)) ^ SEG_POL;
            en_d  = onehot ^ EN_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            idx_q       <= IW'(NUM_DIGITS - 1);
            shadow_q    <= '0;
            seg_q       <= SEG_POL;
            en_q        <= EN_POL;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            en_q        <= en_d;
        end
    end

    assign seg_out  = seg_q;
    assign digit_en = en_q;

`ifdef SEG_MUX_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
    logic                  dp_q, dp_d;

    // Decimal point ignores blanking; it only follows the scan position and polarity.
    always_comb begin
        dp_shadow_d = load ? dp_in : dp_shadow_q;
        dp_d        = dp_q;
        if (tick) begin
            dp_d = POL;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == idx_d) dp_d = dp_shadow_q[i] ^ POL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_shadow_q <= '0;
            dp_q        <= POL;
        end else begin
            dp_shadow_q <= dp_shadow_d;
            dp_q        <= dp_d;
        end
    end

    assign dp_out = dp_q;
`endif

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: two instances (default polarity/div 4, and active-low/div 1)
// checked against a slot-timing reference model plus directed constant expectations.
module tb_seven_segment_mux;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, load, hex_en, blank_lz;
  logic [15:0] val_in;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  en_a, en_b;
`ifdef SEG_MUX_DP_EN
  logic [3:0]  dp_in;
  logic        dp_a, dp_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .val_in(val_in), .hex_en(hex_en), .blank_lz(blank_lz),
`ifdef SEG_MUX_DP_EN
    .dp_in(dp_in), .dp_out(dp_a),
`endif
    .seg_out(seg_a), .digit_en(en_a)
  );

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .val_in(val_in), .hex_en(hex_en), .blank_lz(blank_lz),
`ifdef SEG_MUX_DP_EN
    .dp_in(dp_in), .dp_out(dp_b),
`endif
    .seg_out(seg_b), .digit_en(en_b)
  );

  // Reference model state, one slot per instance.
  logic [6:0]  seg_tbl [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int          rdiv [2] = '{4, 1};
  bit          al   [2] = '{1'b0, 1'b1};
  int          cyc  [2];
  logic [15:0] sh;
  logic [6:0]  exp_seg [2];
  logic [3:0]  exp_en  [2];
`ifdef SEG_MUX_DP_EN
  logic [3:0]  dp_sh;
  logic        exp_dp [2];
`endif

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i, input bit hx, input bit blz);
    int code;
    if (blz && i > 0 && (v >> (4 * i)) == 16'h0) return 7'b0000000;
    code = int'((v >> (4 * i)) & 16'hF);
    if (code > 9 && !hx) return 7'b0000000;
    return seg_tbl[code];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit hx, input bit blz);
    int idx;
    rst = r; load = ld; val_in = v; hex_en = hx; blank_lz = blz;
`ifdef SEG_MUX_DP_EN
    dp_in = v[3:0] ^ v[15:12];
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        cyc[k]     = 0;
        exp_seg[k] = al[k] ? 7'h7F : 7'h00;
        exp_en[k]  = al[k] ? 4'hF : 4'h0;
`ifdef SEG_MUX_DP_EN
        exp_dp[k]  = al[k];
`endif
      end else begin
        cyc[k]++;
        if (cyc[k] % rdiv[k] == 0) begin
          idx        = (cyc[k] / rdiv[k] - 1) % N;
          exp_seg[k] = ref_seg(sh, idx, hx, blz) ^ (al[k] ? 7'h7F : 7'h00);
          exp_en[k]  = (4'b0001 << idx) ^ (al[k] ? 4'hF : 4'h0);
`ifdef SEG_MUX_DP_EN
          exp_dp[k]  = dp_sh[idx] ^ al[k];
`endif
        end
      end
    end
    if (r) sh = 16'h0;
    else if (ld) sh = v;
`ifdef SEG_MUX_DP_EN
    if (r) dp_sh = 4'h0;
    else if (ld) dp_sh = v[3:0] ^ v[15:12];
`endif
    #1;
    chk("model_seg_a", 32'(seg_a), 32'(exp_seg[0]));
    chk("model_en_a",  32'(en_a),  32'(exp_en[0]));
    chk("model_seg_b", 32'(seg_b), 32'(exp_seg[1]));
    chk("model_en_b",  32'(en_b),  32'(exp_en[1]));
`ifdef SEG_MUX_DP_EN
    chk("model_dp_a", 32'(dp_a), 32'(exp_dp[0]));
    chk("model_dp_b", 32'(dp_b), 32'(exp_dp[1]));
`endif
  endtask

  task automatic idle(input int n, input bit hx, input bit blz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, hx, blz);
  endtask

  logic [3:0] t_en  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [6:0] t2    [5] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b0110011};
  logic [6:0] t3h   [4] = '{7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111};
  logic [6:0] t4b   [4] = '{7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000};
  logic [6:0] t4n   [4] = '{7'b1111110, 7'b1110000, 7'b1111110, 7'b1111110};

  initial begin
    rst = 1'b1; load = 1'b0; val_in = '0; hex_en = 1'b0; blank_lz = 1'b0;
`ifdef SEG_MUX_DP_EN
    dp_in = '0;
`endif
    sh = '0;

    // Reset state and first tick
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_seg_a", 32'(seg_a), 32'h0);
    chk("rst_en_a",  32'(en_a),  32'h0);
    chk("rst_seg_b", 32'(seg_b), 32'h7F);
    chk("rst_en_b",  32'(en_b),  32'hF);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0, 1'b0);
      chk("pre_tick_seg", 32'(seg_a), 32'h0);
      chk("pre_tick_en",  32'(en_a),  32'h0);
    end
    idle(1, 1'b0, 1'b0);
    chk("first_tick_en",  32'(en_a),  32'h1);
    chk("first_tick_seg", 32'(seg_a), 32'(7'b1111110));

    // 1234 scan order and wrap
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      idle(s == 0 ? 1 : 4, 1'b0, 1'b0);
      chk("scan1234_en",  32'(en_a),  32'(t_en[s]));
      chk("scan1234_seg", 32'(seg_a), 32'(t2[s]));
    end

    // ABCD with hex on, then off
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    for (int s = 0; s < 8; s++) begin
      idle(s == 0 ? 1 : 4, s < 4, 1'b0);
      chk("hex_seg", 32'(seg_a), s < 4 ? 32'(t3h[s]) : 32'h0);
    end

    // Leading-zero blanking on, then off
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0070, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      idle(s == 0 ? 1 : 4, 1'b0, s < 4);
      chk("blank_en",  32'(en_a),  32'(t_en[s % 4]));
      chk("blank_seg", 32'(seg_a), s < 4 ? 32'(t4b[s]) : 32'(t4n[s - 4]));
    end

    // Reset in the middle of the digit-2 slot clears the shadow
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    idle(11, 1'b0, 1'b0);
    chk("mid_slot_en", 32'(en_a), 32'h4);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("midrst_seg", 32'(seg_a), 32'h0);
    chk("midrst_en",  32'(en_a),  32'h0);
    idle(4, 1'b0, 1'b0);
    chk("midrst_tick_en",  32'(en_a),  32'h1);
    chk("midrst_tick_seg", 32'(seg_a), 32'(7'b1111110));

    // Active-low, div-1 instance with an 8 in digit 0
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("al_rst_seg", 32'(seg_b), 32'h7F);
    chk("al_rst_en",  32'(en_b),  32'hF);
    step(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    chk("al_digit3_en", 32'(en_b), 32'(4'b0111));
    idle(1, 1'b0, 1'b0);
    chk("al_digit0_seg", 32'(seg_b), 32'h0);
    chk("al_digit0_en",  32'(en_b),  32'(4'b1110));

    // Randomized run with occasional loads and resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
